// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide, word-addressed data memory.
// Sub-word stores are done as read-modify-write.
module lsu_mem_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_wd;
  logic [DATA_W-1:0] r_merge;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_err;
  logic [4:0]        w_sh;
  logic [15:0]       w_sel;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_ins;
  logic [DATA_W-1:0] w_merge;

  assign w_err = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign w_sh  = {r_off, 3'b000};
  assign w_sel = 16'(mem_rdata >> w_sh);

  always_comb begin
    w_load = mem_rdata;
    unique case (r_size)
      2'b00: w_load = r_uns
        ? {{(DATA_W-8){1'b0}}, w_sel[7:0]}
        : {{(DATA_W-8){w_sel[7]}}, w_sel[7:0]};
      2'b01: w_load = r_uns
        ? {{(DATA_W-16){1'b0}}, w_sel}
        : {{(DATA_W-16){w_sel[15]}}, w_sel};
      default: w_load = mem_rdata;
    endcase
  end

  // Only the addressed lane of the read word is replaced.
  always_comb begin
    w_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
    if (r_size == 2'b01)
      w_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
    w_mask = w_mask << w_sh;
  end

  assign w_ins   = {{(DATA_W-16){1'b0}}, r_wd} << w_sh;
  assign w_merge = (mem_rdata & ~w_mask) | (w_ins & w_mask);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_off   <= '0;
      r_idx   <= '0;
      r_wd    <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_off   <= req_addr[1:0];
            r_idx   <= req_addr[ADDR_W+1:2];
            r_wd    <= req_wdata[15:0];
            r_merge <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_err;
            if (w_err)
              r_state <= S_RESP;
            else if (!req_we)
              r_state <= S_RD;
            else if (req_size == 2'b10)
              r_state <= S_WR;
            else
              r_state <= S_RMW_RD;
          end
        end
        S_RD: begin
          r_rdata <= w_load;
          r_state <= S_RESP;
        end
        S_RMW_RD: begin
          r_merge <= w_merge;
          r_state <= S_WR;
        end
        S_WR:
          r_state <= S_RESP;
        S_RESP:
          if (resp_ready)
            r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_re     = (r_state == S_RD)
                   || (r_state == S_RMW_RD);
  assign mem_we     = (r_state == S_WR);
  assign mem_addr   = r_idx;
  assign mem_wdata  = r_merge;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master.
// Reference memory and response rules kept as a plain behavioural model.
module tb_lsu_mem_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        mem_re;
  logic        busy;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  int vecs = 0;
  int errs = 0;

  lsu_mem_master #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_re(mem_re), .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      chk("re_we_excl", {31'b0, mem_re & mem_we}, 32'd0);
      chk("busy_ready", {31'b0, busy}, {31'b0, ~req_ready});
    end
  end

  // Expected response, latency and access cycles from the spec rules.
  task automatic model(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [6:0] a,
                       input logic [31:0] wd, output logic err,
                       output logic [31:0] rd, output int lat,
                       output int rem, output int wem);
    int off = int'(a[1:0]);
    int idx = int'(a[6:2]);
    logic [31:0] w = ref_mem[idx];
    logic [7:0] b;
    logic [15:0] h;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0])
       || (sz == 2'd2 && a[1:0] != 2'd0);
    rd = '0; rem = 0; wem = 0; lat = 1;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2; rem = 2;
      if (sz == 2'd0) begin
        b = w[off*8 +: 8];
        rd = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end else if (sz == 2'd1) begin
        h = (off == 0) ? w[15:0] : w[31:16];
        rd = uns ? {16'b0, h} : {{16{h[15]}}, h};
      end else begin
        rd = w;
      end
    end else if (sz == 2'd2) begin
      lat = 2; wem = 2;
      ref_mem[idx] = wd;
    end else begin
      lat = 3; rem = 2; wem = 4;
      if (sz == 2'd0) ref_mem[idx][off*8 +: 8] = wd[7:0];
      else if (off == 0) ref_mem[idx][15:0] = wd[15:0];
      else ref_mem[idx][31:16] = wd[15:0];
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [6:0] a,
                     input logic [31:0] wd, input int stall,
                     output logic [31:0] rd);
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, e_re, e_we;
    int re_m = 0;
    int we_m = 0;
    int cyc = 1;
    model(we, sz, uns, a, wd, e_err, e_rd, e_lat, e_re, e_we);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    resp_ready = (stall == 0);
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    step;
    req_valid = 1'b0;
    while (!resp_valid && cyc < 8) begin
      re_m |= int'(mem_re) << cyc;
      we_m |= int'(mem_we) << cyc;
      if (mem_re || mem_we)
        chk("mem_addr", {27'b0, mem_addr}, {27'b0, a[6:2]});
      step;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("re_cycles", 32'(re_m), 32'(e_re));
    chk("we_cycles", 32'(we_m), 32'(e_we));
    chk("rdata", resp_rdata, e_rd);
    chk("err", {31'b0, resp_err}, {31'b0, e_err});
    rd = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, e_rd);
      chk("bp_err", {31'b0, resp_err}, {31'b0, e_err});
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_mem", {30'b0, mem_re, mem_we}, 32'd0);
      req_valid = 1'b1;
      req_we = 1'($urandom);
      req_size = 2'($urandom);
      req_addr = 7'($urandom);
      req_wdata = $urandom;
      step;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    chk("resp_hold", {31'b0, resp_valid}, 32'd1);
    step;
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_valid", {31'b0, resp_valid}, 32'd0);
    chk("mem_word", mem[a[6:2]], ref_mem[a[6:2]]);
  endtask

  initial begin
    logic [31:0] rd;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem", {29'b0, mem_we, mem_re, busy}, 32'd0);
    chk("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    RST = 1'b0;
    step;

    for (int i = 0; i < 32; i++)
      txn(1'b1, 2'd2, 1'b0, 7'(i << 2), $urandom, 0, rd);

    txn(1'b1, 2'd2, 1'b0, 7'h08, 32'hDEADBEEF, 0, rd);
    chk("tp_mem2", mem[2], 32'hDEADBEEF);
    txn(1'b0, 2'd2, 1'b0, 7'h08, 32'h0, 0, rd);
    chk("tp_lw", rd, 32'hDEADBEEF);

    txn(1'b1, 2'd2, 1'b0, 7'h04, 32'h11223344, 0, rd);
    txn(1'b1, 2'd0, 1'b0, 7'h06, 32'h000000AA, 0, rd);
    chk("tp_sb", mem[1], 32'h11AA3344);

    txn(1'b1, 2'd2, 1'b0, 7'h0C, 32'h80FF7F01, 0, rd);
    txn(1'b0, 2'd0, 1'b0, 7'h0D, 32'h0, 0, rd);
    chk("tp_lb_0d", rd, 32'h0000007F);
    txn(1'b0, 2'd0, 1'b0, 7'h0E, 32'h0, 0, rd);
    chk("tp_lb_0e", rd, 32'hFFFFFFFF);
    txn(1'b0, 2'd0, 1'b1, 7'h0E, 32'h0, 0, rd);
    chk("tp_lbu_0e", rd, 32'h000000FF);
    txn(1'b0, 2'd1, 1'b0, 7'h0E, 32'h0, 0, rd);
    chk("tp_lh_0e", rd, 32'hFFFF80FF);
    txn(1'b0, 2'd1, 1'b1, 7'h0E, 32'h0, 0, rd);
    chk("tp_lhu_0e", rd, 32'h000080FF);

    txn(1'b0, 2'd2, 1'b0, 7'h09, 32'h0, 0, rd);
    txn(1'b0, 2'd1, 1'b0, 7'h03, 32'h0, 0, rd);
    txn(1'b0, 2'd3, 1'b0, 7'h00, 32'h0, 0, rd);
    txn(1'b1, 2'd3, 1'b0, 7'h08, 32'h12345678, 0, rd);
    txn(1'b1, 2'd1, 1'b0, 7'h09, 32'h12345678, 0, rd);
    chk("tp_err_mem", mem[2], 32'hDEADBEEF);

    txn(1'b0, 2'd2, 1'b0, 7'h08, 32'h0, 5, rd);
    chk("tp_bp_rdata", rd, 32'hDEADBEEF);

    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 7'h04; req_wdata = 32'h55; req_valid = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    chk("rw_we_before", {31'b0, mem_we}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rw_we_async", {31'b0, mem_we}, 32'd0);
    chk("rw_busy_async", {31'b0, busy}, 32'd0);
    chk("rw_valid_async", {31'b0, resp_valid}, 32'd0);
    step;
    RST = 1'b0;
    step;
    chk("rw_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rw_valid_after", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 7'h04, 32'h0, 0, rd);
    chk("rw_load", rd, 32'h11AA3344);

    for (int i = 0; i < 300; i++)
      txn(1'($urandom), 2'($urandom), 1'($urandom), 7'($urandom),
          $urandom, int'($urandom_range(0, 3)), rd);

    for (int i = 0; i < 32; i++)
      chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-wide data memory. The memory has a combinational read, a posedge write, no byte enables, and is addressed by word index.
- Accepts one load or store per valid/ready handshake from the execute stage.
- Performs sub-word stores as read-modify-write.
- Returns sign- or zero-extended load data, or an error, through a valid/ready response channel.

Parameters:
- DATA_W, 32, data word width; must equal the memory word width.
- ADDR_W, 5, memory word-address width; memory depth is 2**ADDR_W words.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] = word index, [1:0] = byte offset.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr).
- mem_we  out  1  memory write enable, asserted-level 1.
- mem_re  out  1  memory read enable, asserted-level 1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; all registers cleared.
  - req_ready = 1; resp_valid, resp_err, mem_we, mem_re, busy = 0; mem_addr, mem_wdata, resp_rdata = 0.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - Request accepted when req_valid & req_ready. Accepting latches we, size, unsigned, addr and wdata.
  - Error case: size = 11, half with addr[0] = 1, or word with addr[1:0] != 00. Go to RESP with err = 1 and no memory access.
  - Load goes to RD. Word store goes to WR with merge = wdata. Byte or half store goes to RMW_RD.
- RD:
  - mem_re = 1, mem_addr = latched word index.
  - At the edge, select the byte/half at offset from mem_rdata, then sign- or zero-extend (word passes through). Register into resp_rdata and go to RESP.
- RMW_RD:
  - mem_re = 1.
  - At the edge, merge = mem_rdata with the target byte/half lane replaced by wdata[7:0] or wdata[15:0]. Lane = offset*8 bits. Go to WR.
- WR:
  - mem_we = 1, mem_wdata = merge, mem_re = 0 for exactly one cycle.
  - The write commits at that edge; go to RESP.
- RESP:
  - resp_valid = 1, with rdata and err held stable.
  - Stay until resp_ready = 1; on that edge go to IDLE.
  - req_ready = 0, so no new request is accepted in the same cycle.
- mem_re and mem_we are registered-state decodes. They are never both 1, and both are 0 outside RD/RMW_RD/WR.
- Latency, accept edge = cycle 0, resp_ready held high:
  - load: resp_valid in cycle 2.
  - word store: cycle 2.
  - sub-word store: cycle 3.
  - error: cycle 1.
- Back-pressure: responses held indefinitely; the memory is not touched while in RESP.
- Offset wrap: word index is taken only from addr[ADDR_W+1:2]; address bits above that do not exist.
- RST asserted during WR: mem_we drops immediately. A write at that edge is not guaranteed, and no response is produced.
- resp_err does not modify memory.

Test Plan:
- Word store then load: store addr 0x08 size 10 data 0xDEADBEEF; load addr 0x08 -> mem word[2] = 0xDEADBEEF, resp_rdata 0xDEADBEEF. Latencies 2 and 2.
- Byte store RMW: word[1] = 0x11223344; store byte addr 0x06 data 0xAA -> word[1] = 0x11AA3344. mem_re in cycle 1, mem_we in cycle 2, resp_valid in cycle 3.
- Load extension: word[3] = 0x80FF7F01; lb 0x0D -> 0x0000007F; lb 0x0E -> 0xFFFFFFFF; lbu 0x0E -> 0x000000FF; lh 0x0E -> 0xFFFF80FF; lhu 0x0E -> 0x000080FF.
- Errors: lw 0x09, lh 0x03, size 11 -> resp_err = 1 in cycle 1, rdata 0, mem_re/mem_we never asserted, memory unchanged.
- Back-pressure: resp_ready = 0 for 5 cycles -> resp_valid held with stable data, req_ready = 0, new req_valid ignored. Raising resp_ready -> IDLE next cycle, then the next request is accepted.
- Async reset in WR: assert RST mid-cycle -> mem_we, busy, resp_valid go to 0 without a clock edge. req_ready = 1 after release, and a subsequent load works.
